// File: rtl/p2s_pkg.sv
// Shared types and helpers for the framed parallel-to-serial stage.
package p2s_pkg;

    // Controller states: nothing loaded, or a word is being shifted out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Widest word the parity helper reduces over; narrower words are zero-extended.
    localparam int unsigned PAR_MAX_W = 64;

    // Parity bit for a word; zero-extension does not change the XOR reduction.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Serial bits per word: data bits plus the optional parity bit.
    function automatic int unsigned calc_nb(input int unsigned data_w, input bit parity_en);
        return data_w + (parity_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/p2s_frame_counter.sv
// Word index within a frame, wrapping at FRAME_LEN, plus a registered last-word flag.
module p2s_frame_counter #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance_i,
    output logic [CNT_W-1:0] word_count_o,
    output logic             last_word_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             last_word_q, last_word_d;

    // Next word index: advance once per completed word, wrap after the final word.
    always_comb begin
        word_count_d = word_count_q;
        if (advance_i) begin
            word_count_d = last_word_q ? '0 : word_count_q + CNT_W'(1);
        end
        last_word_d = (word_count_d == CNT_LAST);
    end

    // Counter and flag registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q <= '0;
            last_word_q  <= (FRAME_LEN == 1);
        end else begin
            word_count_q <= word_count_d;
            last_word_q  <= last_word_d;
        end
    end

    assign word_count_o = word_count_q;
    assign last_word_o  = last_word_q;

endmodule

// File: rtl/p2s_framed_serializer.sv
// Parallel-to-serial converter with selectable bit order, optional parity and frame marking.
module p2s_framed_serializer
    import p2s_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned CNT_W      = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] parallel_data,
    input  logic              parallel_valid,
    output logic              parallel_ready_out,
    output logic              serial_data,
    output logic              serial_valid,
    input  logic              serial_ready_in,
    output logic              serial_last,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy
);

    localparam int unsigned      NB      = calc_nb(DATA_W, PARITY_EN);
    localparam int unsigned      BC_W    = $clog2(NB);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(NB - 1);

    state_e            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0] data_ord_c;
    logic [NB-1:0]     load_c;
    logic              on_last_c;
    logic              accept_c;
    logic              word_done_c;
    logic              last_word_c;

    // The shifter always emits from its MSB, so LSB-first words are bit-reversed at load.
    if (MSB_FIRST) begin : g_msb
        assign data_ord_c = parallel_data;
    end else begin : g_lsb
        always_comb begin
            data_ord_c = '0;
            for (int i = 0; i < int'(DATA_W); i++) begin
                data_ord_c[i] = parallel_data[DATA_W-1-i];
            end
        end
    end

    // Parity, when enabled, trails the data bits in the shift register.
    if (PARITY_EN) begin : g_par
        logic par_c;
        assign par_c  = calc_parity(PAR_MAX_W'(parallel_data), PARITY_ODD);
        assign load_c = {data_ord_c, par_c};
    end else begin : g_nopar
        assign load_c = data_ord_c;
    end

    assign on_last_c          = (bit_cnt_q == BC_LAST);
    assign parallel_ready_out = !reset && ((state_q == IDLE) || (on_last_c && serial_ready_in));
    assign accept_c           = parallel_valid && parallel_ready_out;
    assign word_done_c        = (state_q == SHIFT) && on_last_c && serial_ready_in;

    // Next state: load on accept, otherwise shift on each consumed bit until the word ends.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (accept_c) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            shreg_d   = load_c;
        end else if ((state_q == SHIFT) && serial_ready_in) begin
            if (on_last_c) begin
                state_d = IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                shreg_d   = {shreg_q[NB-2:0], 1'b0};
            end
        end
    end

    // State, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    p2s_frame_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_frame_counter (
        .clk          (clk),
        .reset        (reset),
        .advance_i    (word_done_c),
        .word_count_o (word_count),
        .last_word_o  (last_word_c)
    );

    assign serial_valid = (state_q == SHIFT);
    assign serial_data  = shreg_q[NB-1];
    assign serial_last  = serial_valid && on_last_c && last_word_c;
    assign busy         = serial_valid;

endmodule

// File: tb/tb_p2s_framed_serializer.sv
// Bench for p2s_framed_serializer: three configurations, scoreboard of expected serial bits.
module tb_p2s_framed_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pd;
    logic       pv;
    logic       srdy;
    int         sel;

    always #5 clk = ~clk;

    // Per-instance configuration: A msb/no-parity/frame 4, B lsb/even/frame 16, C lsb/odd/frame 1.
    int cfg_msb  [3] = '{1, 0, 0};
    int cfg_par  [3] = '{0, 1, 1};
    int cfg_odd  [3] = '{0, 0, 1};
    int cfg_flen [3] = '{4, 16, 1};

    logic       pv_a, pv_b, pv_c;
    logic       rdy_a, rdy_b, rdy_c, sd_a, sd_b, sd_c, sv_a, sv_b, sv_c;
    logic       sl_a, sl_b, sl_c, bz_a, bz_b, bz_c;
    logic [2:0] wc_a;
    logic [4:0] wc_b;
    logic [0:0] wc_c;

    assign pv_a = pv && (sel == 0);
    assign pv_b = pv && (sel == 1);
    assign pv_c = pv && (sel == 2);

    p2s_framed_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .FRAME_LEN(4)) u_a (
        .clk(clk), .reset(reset), .parallel_data(pd), .parallel_valid(pv_a), .parallel_ready_out(rdy_a),
        .serial_data(sd_a), .serial_valid(sv_a), .serial_ready_in(srdy), .serial_last(sl_a),
        .word_count(wc_a), .busy(bz_a));

    p2s_framed_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FRAME_LEN(16)) u_b (
        .clk(clk), .reset(reset), .parallel_data(pd), .parallel_valid(pv_b), .parallel_ready_out(rdy_b),
        .serial_data(sd_b), .serial_valid(sv_b), .serial_ready_in(srdy), .serial_last(sl_b),
        .word_count(wc_b), .busy(bz_b));

    p2s_framed_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .FRAME_LEN(1)) u_c (
        .clk(clk), .reset(reset), .parallel_data(pd), .parallel_valid(pv_c), .parallel_ready_out(rdy_c),
        .serial_data(sd_c), .serial_valid(sv_c), .serial_ready_in(srdy), .serial_last(sl_c),
        .word_count(wc_c), .busy(bz_c));

    // Outputs of the instance currently under test.
    logic       cur_rdy, cur_sd, cur_sv, cur_sl, cur_bz;
    logic [7:0] cur_wc;
    always_comb begin
        cur_rdy = rdy_a; cur_sd = sd_a; cur_sv = sv_a; cur_sl = sl_a; cur_bz = bz_a; cur_wc = 8'(wc_a);
        if (sel == 1) begin
            cur_rdy = rdy_b; cur_sd = sd_b; cur_sv = sv_b; cur_sl = sl_b; cur_bz = bz_b; cur_wc = 8'(wc_b);
        end else if (sel == 2) begin
            cur_rdy = rdy_c; cur_sd = sd_c; cur_sv = sv_c; cur_sl = sl_c; cur_bz = bz_c; cur_wc = 8'(wc_c);
        end
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected emission order (index 0 first) computed from the bit-order and parity rules.
    function automatic logic [0:8] gen_exp(input int s, input logic [7:0] d);
        logic [0:8] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = (cfg_msb[s] != 0) ? d[7-i] : d[i];
        if (cfg_par[s] != 0) r[8] = (^d) ^ (cfg_odd[s] != 0);
        return r;
    endfunction

    typedef struct {
        logic b;
        logic last;
        int   wc;
    } bit_t;

    bit_t       sb[$];
    int         wc_m [3] = '{0, 0, 0};
    logic [0:8] pend_exp;
    int         pend_nb;
    bit         acc_seen;
    int         pop_cnt = 0;
    bit         rnd_rdy = 1'b0;

    // Scoreboard: compare current bit against queue head, model ready, pop on consume, push on accept.
    always @(negedge clk) begin
        logic ev, er;
        bit_t e;
        ev = (sb.size() != 0);
        chk("serial_valid", 32'(cur_sv), 32'(ev));
        chk("busy", 32'(cur_bz), 32'(ev));
        if (ev) begin
            chk("serial_data", 32'(cur_sd), 32'(sb[0].b));
            chk("serial_last", 32'(cur_sl), 32'(sb[0].last));
            chk("word_count", 32'(cur_wc), 32'(sb[0].wc));
        end
        er = !reset && ((sb.size() == 0) || ((sb.size() == 1) && srdy));
        chk("parallel_ready_out", 32'(cur_rdy), 32'(er));
        if (reset) begin
            sb.delete();
            wc_m = '{0, 0, 0};
        end else begin
            if (ev && srdy) begin
                void'(sb.pop_front());
                pop_cnt++;
            end
            if (er && pv) begin
                for (int i = 0; i < pend_nb; i++) begin
                    e.b    = pend_exp[i];
                    e.last = (i == pend_nb - 1) && (wc_m[sel] == cfg_flen[sel] - 1);
                    e.wc   = wc_m[sel];
                    sb.push_back(e);
                end
                wc_m[sel] = (wc_m[sel] + 1) % cfg_flen[sel];
                acc_seen  = 1'b1;
            end
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 srdy = 1'($urandom_range(0, 1));
        end
    end

    // Present a word and hold valid until accepted; valid stays high on return.
    task automatic send(input int s, input logic [7:0] d, input logic [0:8] e);
        sel      = s;
        pd       = d;
        pend_exp = e;
        pend_nb  = (cfg_par[s] != 0) ? 9 : 8;
        acc_seen = 1'b0;
        pv       = 1'b1;
        for (int k = 0; k < 80 && !acc_seen; k++) begin
            @(posedge clk);
            #1;
        end
        if (!acc_seen) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL accept_timeout: word %0h not accepted, expected accept within 80 cycles", d);
        end
    endtask

    task automatic idle();
        pv = 1'b0;
        pd = 8'($urandom);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: %0d bits pending, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    typedef struct {
        int         s;
        logic [7:0] d;
        logic [0:8] exp;
        bit         chain;
    } vec_t;

    vec_t vt [8];

    initial begin
        int         p0;
        int         pat [12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic [7:0] w;

        vt[0] = '{s: 0, d: 8'hA5, exp: 9'b101001010, chain: 1'b0};
        vt[1] = '{s: 1, d: 8'h07, exp: 9'b111000001, chain: 1'b0};
        vt[2] = '{s: 2, d: 8'h07, exp: 9'b111000000, chain: 1'b0};
        vt[3] = '{s: 1, d: 8'h3C, exp: 9'b001111000, chain: 1'b0};
        vt[4] = '{s: 2, d: 8'h80, exp: 9'b000000010, chain: 1'b0};
        vt[5] = '{s: 1, d: 8'hFF, exp: 9'b111111110, chain: 1'b0};
        vt[6] = '{s: 0, d: 8'h01, exp: 9'b000000010, chain: 1'b1};
        vt[7] = '{s: 0, d: 8'h02, exp: 9'b000000100, chain: 1'b0};

        reset = 1'b1;
        pv    = 1'b0;
        pd    = 8'h00;
        srdy  = 1'b1;
        sel   = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_serial_valid", 32'(sv_a), 32'd0);
        chk("reset_serial_data", 32'(sd_a), 32'd0);
        chk("reset_serial_last", 32'(sl_a), 32'd0);
        chk("reset_word_count", 32'(wc_a), 32'd0);
        chk("reset_busy", 32'(bz_a), 32'd0);
        chk("reset_ready", 32'(rdy_a), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 32'(rdy_a), 32'd1);

        // Table of single words and one back-to-back pair.
        for (int v = 0; v < 8; v++) begin
            send(vt[v].s, vt[v].d, vt[v].exp);
            if (!vt[v].chain) begin
                idle();
                drain();
            end
        end

        // Downstream stalls during one word; bits must hold and none be lost or repeated.
        sel = 0;
        p0  = pop_cnt;
        send(0, 8'hC3, 9'b110000110);
        idle();
        for (int i = 0; i < 12; i++) begin
            srdy = 1'(pat[i]);
            @(posedge clk);
            #1;
        end
        srdy = 1'b1;
        drain();
        chk("stall_consumed_bits", 32'(pop_cnt - p0), 32'd8);

        // Nine-word frame stream with an upstream gap mid-frame.
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            w = 8'(i * 37 + 5);
            send(0, w, gen_exp(0, w));
            if (i == 5) begin
                idle();
                repeat (11) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle();
        drain();

        // Random words and backpressure on the LSB-first parity instance.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = 8'($urandom);
            send(1, w, gen_exp(1, w));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat (int'($urandom_range(1, 12))) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle();
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        srdy = 1'b1;
        drain();

        // Reset at bit 3 of word 2 abandons the frame; the next word starts a fresh one.
        pulse_reset();
        send(0, 8'h5A, gen_exp(0, 8'h5A));
        send(0, 8'h96, gen_exp(0, 8'h96));
        send(0, 8'h3E, gen_exp(0, 8'h3E));
        idle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_serial_valid", 32'(sv_a), 32'd0);
        chk("midreset_word_count", 32'(wc_a), 32'd0);
        chk("midreset_serial_last", 32'(sl_a), 32'd0);
        reset = 1'b0;
        #1;
        send(0, 8'hFF, 9'b111111110);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
